math_multiplier_seq: RTL and testbench
======================================

// Module: math_multiplier_seq
// PURPOSE
//   Iterative shift-and-add multiplier. Successor to the combinational array multiplier:
//   N-bit operands, 2N-bit product, computed one partial product per clock.
//   Per-operation signed/unsigned mode; valid/ready handshake on input and output.
//   Used where area matters more than latency in the math library datapaths.
// PARAMETERS
//   N  4  operand width in bits (N>=2); product is 2N bits
// PORTS
//   clk        in   1   single clock, rising-edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   operands a, b, is_signed are valid
//   in_ready   out  1   block can accept operands (high only in IDLE)
//   a          in   N   multiplicand
//   b          in   N   multiplier
//   is_signed  in   1   1: a, b and p are two's complement; 0: unsigned
//   out_valid  out  1   p holds a completed product
//   out_ready  in   1   consumer takes p
//   p          out  2N  product
// BEHAVIOUR
//   Clocking/reset: one clock; reset is asynchronous and active-high.
//   Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, counter=0.
//   Reset mid-operation aborts the operation; no out_valid for the aborted operation.
//   States: IDLE -> BUSY -> FIX -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1.
//     - On edge with in_valid=1: latch operands.
//       - Unsigned mode, or operand >= 0: latch operand as-is.
//       - Signed mode, negative operand: latch |operand|.
//     - |a|, |b| each fit in N unsigned bits; -2^(N-1) gives magnitude 2^(N-1).
//     - Latch neg = is_signed & (a[N-1]^b[N-1]).
//     - Clear accumulator; counter=0; go to BUSY.
//   BUSY:
//     - Each cycle: if multiplier LSB=1, add the multiplicand to the upper half of the accumulator.
//     - Shift multiplier right; increment counter.
//     - After exactly N BUSY cycles, go to FIX.
//     - Accumulator is 2N+1 bits internally, so no carry is lost.
//   FIX:
//     - p <= neg ? -acc : acc, truncated to 2N bits; go to DONE.
//   DONE:
//     - out_valid=1; p is held stable until the handshake.
//     - On edge with out_ready=1: out_valid<=0, go to IDLE.
//   Latency: accept on edge E0 -> out_valid high from edge E0+N+1 (5 cycles for N=4).
//   Throughput: at most one operation per N+3 cycles. in_ready is low in BUSY/FIX/DONE.
//   in_valid while in_ready=0 is ignored; operands are not queued.
//   out_ready while out_valid=0 has no effect.
//   Operand inputs are sampled only on the accepting edge; later changes do not affect p.
//   p value after the handshake: p keeps its last value until the next FIX.
//   Width rules:
//     - Unsigned: p = a*b, 0..(2^N-1)^2, always fits 2N bits.
//     - Signed: p = a*b, range -2^(2N-2)+2^(N-1) .. 2^(2N-2); always exact in 2N-bit two's complement.
// TESTING
//   1. Exhaustive N=4, both modes, out_ready=1: all 256 a,b pairs -> p == a*b;
//      signed pairs compared as signed; out_valid exactly N+1 edges after accept.
//   2. Unsigned a=15, b=15 -> p=8'hE1 (225); signed a=4'h8, b=4'h8 (-8*-8) -> p=8'h40 (64).
//   3. Signed a=4'h8, b=4'h7 (-8*7) -> p=8'hC8 (-56); unsigned same bits -> p=8'h38 (56).
//   4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> p and out_valid stable,
//      in_ready=0; release -> out_valid drops next edge, in_ready=1.
//   5. While busy, drive in_valid=1 with a=3, b=3 -> ignored; the first product (a=5, b=6 -> 30)
//      is returned unaltered.
//   6. Assert rst two cycles into BUSY -> out_valid, p, in_ready return to 0, 0, 1 immediately
//      without a clock edge; the next operation (a=2, b=3) -> p=6.

Source files
------------

// File: rtl/math_multiplier_seq.sv
// rtl/math_multiplier_seq.sv - iterative shift-and-add multiplier, signed/unsigned, valid/ready
module math_multiplier_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [N-1:0]     mcand_q;
    logic [N-1:0]     mplier_q;
    logic [2*N:0]     acc_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic [2*N-1:0]   p_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [N-1:0]     mag_a_d;
    logic [N-1:0]     mag_b_d;
    logic             neg_d;
    logic [2*N:0]     acc_d;

    // Operand magnitudes for the accept edge and the next accumulator value for one BUSY step.
    // The accumulator is shifted right after each add, so the multiplicand always lands on the
    // upper half; the extra top bit keeps the carry of that add.
    always_comb begin
        mag_a_d = (is_signed && a[N-1]) ? -a : a;
        mag_b_d = (is_signed && b[N-1]) ? -b : b;
        neg_d   = is_signed & (a[N-1] ^ b[N-1]);
        acc_d   = (mplier_q[0] ? acc_q + {1'b0, mcand_q, {N{1'b0}}} : acc_q) >> 1;
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= mag_a_d;
                        mplier_q   <= mag_b_d;
                        neg_q      <= neg_d;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    p_q         <= neg_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_math_multiplier_seq.sv
// tb/tb_math_multiplier_seq.sv - scoreboard bench for math_multiplier_seq
module tb_math_multiplier_seq;

    localparam int N = 4;

    typedef struct {
        logic [2*N-1:0] p;
        int             acc_cyc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;

    int   total;
    int   bad;
    int   cyc;
    bit   ready_mode;
    bit   seen;
    exp_t cur;
    exp_t sb[$];

    math_multiplier_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // random consumer backpressure, changed well away from both clock edges
    always @(posedge clk) begin
        #2;
        if (ready_mode) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [2*N-1:0] model(logic [N-1:0] x, logic [N-1:0] y, logic s);
        longint vx;
        longint vy;
        longint prod;
        vx = longint'(x);
        vy = longint'(y);
        if (s && x[N-1]) vx = vx - (longint'(1) << N);
        if (s && y[N-1]) vy = vy - (longint'(1) << N);
        prod = vx * vy;
        return prod[2*N-1:0];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: checks each product when out_valid rises, retires it when out_valid falls
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (seen && !out_valid) begin
                if (sb.size() > 0) void'(sb.pop_front());
                seen = 1'b0;
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=%0h required=none", p);
                    end else begin
                        cur = sb[0];
                        check("product", 64'(p), 64'(cur.p));
                        check("latency", 64'(cyc - cur.acc_cyc), 64'(N + 1));
                    end
                end else if (sb.size() > 0) begin
                    check("p_hold", 64'(p), 64'(cur.p));
                end
            end
        end
    end

    task automatic do_op(logic [N-1:0] x, logic [N-1:0] y, logic s, logic [2*N-1:0] e);
        exp_t   item;
        bit     ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            return;
        end
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        is_signed = s;
        item.p       = e;
        item.acc_cyc = cyc + 1;
        sb.push_back(item);
        @(negedge clk);
        in_valid  = 1'b0;
        a         = N'($urandom);
        b         = N'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || seen) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    initial begin
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         s;
        bit           got;

        total = 0; bad = 0; cyc = 0; seen = 1'b0; ready_mode = 1'b0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_p", 64'(p), 64'd0);
        rst = 1'b0;

        // exhaustive, both modes, consumer always ready
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < (1 << N); i++)
                for (int j = 0; j < (1 << N); j++)
                    do_op(N'(i), N'(j), 1'(m), model(N'(i), N'(j), 1'(m)));
        drain();

        // corner products with hand-derived results
        do_op(4'hF, 4'hF, 1'b0, 8'hE1);
        do_op(4'h8, 4'h8, 1'b1, 8'h40);
        do_op(4'h8, 4'h7, 1'b1, 8'hC8);
        do_op(4'h8, 4'h7, 1'b0, 8'h38);
        drain();

        // random operands under random backpressure
        ready_mode = 1'b1;
        for (int k = 0; k < 80; k++) begin
            x = N'($urandom);
            y = N'($urandom);
            s = 1'($urandom);
            do_op(x, y, s, model(x, y, s));
        end
        drain();
        ready_mode = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // backpressure hold
        out_ready = 1'b0;
        do_op(4'h9, 4'h7, 1'b0, 8'h3F);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", 64'(got), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_p", 64'(p), 64'h3F);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // operands offered while busy must be ignored
        do_op(4'd5, 4'd6, 1'b0, 8'd30);
        in_valid = 1'b1; a = 4'd3; b = 4'd3; is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("busy_no_extra_output", 64'(out_valid), 64'd0);

        // asynchronous reset two cycles into BUSY
        do_op(4'd7, 4'd7, 1'b0, 8'd49);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_p", 64'(p), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(4'd2, 4'd3, 1'b0, 8'd6);
        drain();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
